// File: rtl/modet_pkg.sv
// Shared constants and types for the motion-detection write path.
package modet_pkg;

    // Default byte geometry of the pixel stream (B,G,R bytes per word).
    localparam int BYTE_WIDTH     = 8;
    localparam int BYTES_PER_WORD = 3;

    // Default frame size in words (one word per pixel).
    localparam int NUM_WORDS      = 720 * 540;

    // Writer FSM: gathering bytes, or holding a finished word for the FIFO.
    typedef enum logic {
        S_FILL  = 1'b0,
        S_WRITE = 1'b1
    } writer_state_t;

endpackage : modet_pkg

// File: rtl/pixel_fifo_writer.sv
// Write-side producer for the motion-detection dual-clock FIFO.
// Packs BYTES_PER_WORD input bytes (first byte in the LSBs) into one word,
// pushes it into the FIFO while honouring fifo_full, counts words per frame
// and pulses frame_done for one cycle after the last word of each frame.
module pixel_fifo_writer #(
    parameter int BYTE_WIDTH     = modet_pkg::BYTE_WIDTH,
    parameter int BYTES_PER_WORD = modet_pkg::BYTES_PER_WORD,
    parameter int NUM_WORDS      = modet_pkg::NUM_WORDS,
    localparam int WORD_WIDTH    = BYTE_WIDTH * BYTES_PER_WORD,
    localparam int CNT_W         = $clog2(NUM_WORDS)
) (
    input  logic                  wr_clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [BYTE_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [WORD_WIDTH-1:0] fifo_din,
    output logic [CNT_W-1:0]      word_count,
    output logic                  frame_done
);

    import modet_pkg::*;

    localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

    writer_state_t         state_q;
    logic [IDX_W-1:0]      byte_idx_q, byte_idx_d;
    logic [WORD_WIDTH-1:0] pack_q, pack_d;
    logic [WORD_WIDTH-1:0] din_q;
    logic [CNT_W-1:0]      word_count_q, word_count_d;
    logic                  frame_done_q;

    logic accept;
    logic last_byte;
    logic write_fire;

    // Handshake: bytes are only taken while a word is being gathered.
    assign in_ready   = (state_q == S_FILL);
    assign accept     = in_valid && in_ready;
    assign last_byte  = accept && (byte_idx_q == LAST_IDX);

    // Write goes out combinationally so a freed-up FIFO is used the same cycle.
    assign write_fire = (state_q == S_WRITE) && !fifo_full;
    assign fifo_wr_en = write_fire;

    assign fifo_din   = din_q;
    assign word_count = word_count_q;
    assign frame_done = frame_done_q;

    // Each byte lane takes the incoming byte only when it is the lane being filled.
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
        assign pack_d[gi*BYTE_WIDTH +: BYTE_WIDTH] =
            (accept && (byte_idx_q == IDX_W'(gi))) ? in_data
                                                   : pack_q[gi*BYTE_WIDTH +: BYTE_WIDTH];
    end

    // Lane pointer: advance per accepted byte, wrap after the last lane.
    always_comb begin
        byte_idx_d = byte_idx_q;
        if (last_byte) begin
            byte_idx_d = '0;
        end else if (accept) begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
        end
    end

    // Frame word counter wraps at the end of each frame.
    always_comb begin
        word_count_d = word_count_q;
        if (write_fire) begin
            word_count_d = (word_count_q == LAST_WORD) ? '0 : word_count_q + CNT_W'(1);
        end
    end

    // Packing register and lane pointer.
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            pack_q     <= '0;
            byte_idx_q <= '0;
        end else begin
            pack_q     <= pack_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    // Writer FSM: latch the completed word, then hold it until the FIFO takes it.
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FILL;
            din_q   <= '0;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (last_byte) begin
                        state_q <= S_WRITE;
                        din_q   <= pack_d;
                    end
                end
                S_WRITE: begin
                    if (write_fire) begin
                        state_q <= S_FILL;
                    end
                end
                default: state_q <= S_FILL;
            endcase
        end
    end

    // Word count and the one-cycle end-of-frame pulse.
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            word_count_q <= '0;
            frame_done_q <= 1'b0;
        end else begin
            word_count_q <= word_count_d;
            frame_done_q <= write_fire && (word_count_q == LAST_WORD);
        end
    end

    // Writing into a full FIFO would silently drop a pixel.
    a_no_write_when_full: assert property (
        @(posedge wr_clk) disable iff (reset) !(fifo_wr_en && fifo_full)
    );

endmodule : pixel_fifo_writer

// File: tb/tb_pixel_fifo_writer.sv
// Scoreboard bench for pixel_fifo_writer: the driver builds expected words from
// accepted bytes, a negedge monitor compares every DUT output each cycle.
`timescale 1ns/1ps
module tb_pixel_fifo_writer;

    localparam int BW  = 8;
    localparam int BPW = 3;
    localparam int NW  = 4;
    localparam int WW  = BW * BPW;
    localparam int CW  = $clog2(NW);

    logic          wr_clk = 1'b0;
    logic          reset  = 1'b1;
    logic          in_valid = 1'b0;
    logic [BW-1:0] in_data  = '0;
    logic          in_ready;
    logic          fifo_full = 1'b0;
    logic          fifo_wr_en;
    logic [WW-1:0] fifo_din;
    logic [CW-1:0] word_count;
    logic          frame_done;

    pixel_fifo_writer #(
        .BYTE_WIDTH     (BW),
        .BYTES_PER_WORD (BPW),
        .NUM_WORDS      (NW)
    ) dut (
        .wr_clk     (wr_clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .word_count (word_count),
        .frame_done (frame_done)
    );

    always #5 wr_clk = ~wr_clk;

    // Reference model state
    logic [BW-1:0] part_q[$];      // bytes of the word being assembled
    logic [WW-1:0] exp_q[$];       // finished words awaiting a FIFO write
    int            writes_done = 0;
    bit            frame_flag  = 1'b0;
    bit            rand_full   = 1'b0;

    int vectors = 0;
    int errors  = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_accept(input logic [BW-1:0] b);
        logic [WW-1:0] w;
        part_q.push_back(b);
        if (part_q.size() == BPW) begin
            w = '0;
            for (int k = 0; k < BPW; k++) w[k*BW +: BW] = part_q[k];
            exp_q.push_back(w);
            part_q.delete();
            $display("byte 0x%02h accepted -> word 0x%06h expected", b, w);
        end else begin
            $display("byte 0x%02h accepted", b);
        end
    endfunction

    // Idle for `idle` cycles, then offer byte b until the DUT takes it.
    task automatic send_byte(input logic [BW-1:0] b, input int idle);
        bit ok;
        int t;
        repeat (idle) begin
            in_valid = 1'b0;
            @(posedge wr_clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        t  = 0;
        ok = 1'b0;
        while (!ok && t < 200) begin
            @(negedge wr_clk);
            ok = in_ready;
            @(posedge wr_clk); #1;
            t++;
        end
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: byte 0x%02h not taken, in_ready=%0b, required 1", b, in_ready);
        end else begin
            model_accept(b);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge wr_clk); #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        part_q.delete();
        exp_q.delete();
        writes_done = 0;
        frame_flag  = 1'b0;
        $display("reset asserted for %0d cycles", n);
        idle_cycles(n);
        reset = 1'b0;
    endtask

    // Random back-pressure during the soak phase
    always @(posedge wr_clk) begin
        #1;
        if (rand_full) fifo_full = ($urandom_range(0, 2) == 0);
    end

    // Monitor: compare every output against the model, retire words on writes.
    always @(negedge wr_clk) begin
        if (reset) begin
            chk("rst_wr_en",      64'(fifo_wr_en), 64'd0);
            chk("rst_in_ready",   64'(in_ready),   64'd1);
            chk("rst_frame_done", 64'(frame_done), 64'd0);
            chk("rst_word_count", 64'(word_count), 64'd0);
            chk("rst_fifo_din",   64'(fifo_din),   64'd0);
        end else begin
            chk("in_ready",   64'(in_ready),   64'(exp_q.size() == 0));
            chk("wr_en",      64'(fifo_wr_en), 64'((exp_q.size() != 0) && !fifo_full));
            chk("wr_when_full", 64'(fifo_wr_en && fifo_full), 64'd0);
            chk("frame_done", 64'(frame_done), 64'(frame_flag));
            chk("word_count", 64'(word_count), 64'(writes_done % NW));
            if (exp_q.size() != 0) chk("fifo_din", 64'(fifo_din), 64'(exp_q[0]));
            frame_flag = 1'b0;
            if (fifo_wr_en) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: din 0x%06h written, required no write", fifo_din);
                end else begin
                    $display("write 0x%06h (word %0d of frame)", fifo_din, writes_done % NW);
                    void'(exp_q.pop_front());
                end
                writes_done++;
                if (writes_done % NW == 0) frame_flag = 1'b1;
            end
        end
    end

    initial begin
        logic [BW-1:0] b;
        idle_cycles(3);
        reset = 1'b0;

        // Back-to-back bytes, no back-pressure
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        idle_cycles(3);

        // Word held under fifo_full, released after 5 cycles
        fifo_full = 1'b1;
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        idle_cycles(5);
        fifo_full = 1'b0;
        idle_cycles(3);

        // Gappy valid: 1,0,0,1,0,1
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 2);
        send_byte(8'hCC, 1);
        idle_cycles(3);

        // One full frame from a clean start
        do_reset(2);
        for (int i = 0; i < 12; i++) begin
            b = 8'(i);
            send_byte(b, 0);
        end
        idle_cycles(4);

        // Reset after a partial word; those bytes must vanish
        send_byte(8'hE1, 0);
        send_byte(8'hE2, 0);
        do_reset(3);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        idle_cycles(3);

        // Random soak with random back-pressure and input gaps
        rand_full = 1'b1;
        for (int i = 0; i < 300 * BPW; i++) begin
            b = 8'($urandom);
            send_byte(b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
        end
        rand_full = 1'b0;
        fifo_full = 1'b0;
        idle_cycles(5);
        chk("drain_pending_words", 64'(exp_q.size()), 64'd0);
        chk("drain_partial_bytes", 64'(part_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_pixel_fifo_writer
